// File: rtl/redirect_controller_pkg.sv
// redirect_controller_pkg: shared FSM state and redirect-source encodings
package redirect_controller_pkg;
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;
  typedef enum logic {
    BRANCH = 1'b0,
    RESUME = 1'b1
  } src_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter (inc, async active-low clear rst_n) -> count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/redirect_controller.sv
// redirect_controller: EX redirect/halt capture, fetch handshake, front-end flush, halt/resume, taken counter (ports: ex_*, resume*, fetch_ready in; redirect_*, flush_*, halted, taken_count out)
module redirect_controller
  import redirect_controller_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_jump_valid,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_halt,
  input  logic              resume,
  input  logic [ADDR_W-1:0] resume_addr,
  input  logic              fetch_ready,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              flush_front,
  output logic              flush_ex,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_count
);
  state_t            state, state_next;
  src_t              src, src_next;
  logic [ADDR_W-1:0] addr_next;
  logic              fire;
  assign fire = ex_valid & ex_jump_valid & ~ex_stall;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= RUN;
      src            <= BRANCH;
      redirect_addr  <= '0;
      redirect_valid <= 1'b0;
      flush_front    <= 1'b0;
      flush_ex       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_next;
      src            <= src_next;
      redirect_addr  <= addr_next;
      redirect_valid <= state_next == WAIT;
      flush_front    <= state_next != RUN;
      flush_ex       <= state_next == WAIT;
      halted         <= state_next == HALT;
    end
  always_comb begin
    state_next = state;
    src_next   = src;
    addr_next  = redirect_addr;
    case (state)
      RUN:
        if (fire && ex_halt) state_next = HALT;
        else if (fire) begin
          state_next = WAIT;
          src_next   = BRANCH;
          addr_next  = ex_jump_addr;
        end
      WAIT: state_next = fetch_ready ? RUN : WAIT;
      HALT:
        if (resume) begin
          state_next = WAIT;
          src_next   = RESUME;
          addr_next  = resume_addr;
        end
      default: state_next = RUN;
    endcase
  end
  sat_counter #(.WIDTH(CNT_W)) u_taken (
    .clk  (clk),
    .rst_n(reset_n),
    .inc  (redirect_valid & fetch_ready & (src == BRANCH)),
    .count(taken_count)
  );
endmodule

// File: tb/tb_redirect_controller.sv
// tb_redirect_controller: directed self-checking bench for redirect_controller
module tb_redirect_controller;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_stall, ex_jump_valid, ex_halt, resume, fetch_ready;
  logic [31:0] ex_jump_addr, resume_addr, redirect_addr;
  logic        redirect_valid, flush_front, flush_ex, halted;
  logic [3:0]  taken_count;
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;
  always #5 clk = ~clk;
  redirect_controller #(.ADDR_W(32), .CNT_W(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_jump_valid (ex_jump_valid),
    .ex_jump_addr  (ex_jump_addr),
    .ex_halt       (ex_halt),
    .resume        (resume),
    .resume_addr   (resume_addr),
    .fetch_ready   (fetch_ready),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .flush_front   (flush_front),
    .flush_ex      (flush_ex),
    .halted        (halted),
    .taken_count   (taken_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic outs(input string tag, input logic rv, input logic ff, input logic fe, input logic h);
    check({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".flush_front"}, {31'd0, flush_front}, {31'd0, ff});
    check({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, fe});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
  endtask
  task automatic idle_ex();
    ex_valid = 0; ex_stall = 0; ex_jump_valid = 0; ex_halt = 0; resume = 0;
  endtask
  task automatic jump(input logic [31:0] a);
    ex_valid = 1; ex_jump_valid = 1; ex_jump_addr = a;
  endtask
  initial begin
    reset_n = 0; idle_ex(); fetch_ready = 0; ex_jump_addr = 0; resume_addr = 0;
    #1;
    outs("reset", 0, 0, 0, 0);
    check("reset.addr", redirect_addr, 0);
    check("reset.count", {28'd0, taken_count}, 0);
    #22 reset_n = 1;
    step();
    step();
    outs("idle", 0, 0, 0, 0);
    jump(32'h1234); fetch_ready = 1;
    step();
    outs("jmp.n1", 1, 1, 1, 0);
    check("jmp.addr", redirect_addr, 32'h1234);
    idle_ex();
    step();
    exp_cnt = 1;
    outs("jmp.n2", 0, 0, 0, 0);
    check("jmp.count", {28'd0, taken_count}, exp_cnt);
    jump(32'h1234); fetch_ready = 0;
    step();
    outs("wait.w1", 1, 1, 1, 0);
    jump(32'h9999);
    step();
    outs("wait.w2", 1, 1, 1, 0);
    step();
    outs("wait.w3", 1, 1, 1, 0);
    check("wait.count_held", {28'd0, taken_count}, exp_cnt);
    step();
    outs("wait.w4", 1, 1, 1, 0);
    check("wait.addr", redirect_addr, 32'h1234);
    fetch_ready = 1;
    step();
    idle_ex();
    exp_cnt = 2;
    outs("wait.done", 0, 0, 0, 0);
    check("wait.count", {28'd0, taken_count}, exp_cnt);
    check("wait.addr_kept", redirect_addr, 32'h1234);
    jump(32'h300); ex_stall = 1;
    step();
    outs("stall.1", 0, 0, 0, 0);
    step();
    outs("stall.2", 0, 0, 0, 0);
    ex_stall = 0;
    step();
    idle_ex();
    outs("stall.fire", 1, 1, 1, 0);
    check("stall.addr", redirect_addr, 32'h300);
    step();
    exp_cnt = 3;
    outs("stall.done", 0, 0, 0, 0);
    step();
    outs("stall.once", 0, 0, 0, 0);
    check("stall.count", {28'd0, taken_count}, exp_cnt);
    jump(32'h40); ex_halt = 1;
    step();
    idle_ex();
    outs("halt.1", 0, 1, 0, 1);
    check("halt.addr_untouched", redirect_addr, 32'h300);
    step();
    outs("halt.2", 0, 1, 0, 1);
    resume = 1; resume_addr = 32'h200;
    step();
    resume = 0;
    outs("resume.1", 1, 1, 1, 0);
    check("resume.addr", redirect_addr, 32'h200);
    step();
    outs("resume.done", 0, 0, 0, 0);
    check("resume.count", {28'd0, taken_count}, exp_cnt);
    resume = 1; resume_addr = 32'h700;
    step();
    resume = 0;
    outs("resume_in_run", 0, 0, 0, 0);
    jump(32'h500); resume = 1; resume_addr = 32'h600;
    step();
    idle_ex();
    outs("fire_resume", 1, 1, 1, 0);
    check("fire_resume.addr", redirect_addr, 32'h500);
    step();
    exp_cnt = 4;
    check("fire_resume.count", {28'd0, taken_count}, exp_cnt);
    for (int i = 0; i < 14; i++) begin
      jump(32'h1000 + i);
      step();
      idle_ex();
      step();
      exp_cnt = exp_cnt < 15 ? exp_cnt + 1 : 15;
      check($sformatf("sat.%0d", i), {28'd0, taken_count}, exp_cnt);
    end
    check("sat.final", {28'd0, taken_count}, 15);
    jump(32'hABC); fetch_ready = 0;
    step();
    idle_ex();
    outs("arst.pre", 1, 1, 1, 0);
    #2 reset_n = 0;
    #1;
    outs("arst.async", 0, 0, 0, 0);
    check("arst.count", {28'd0, taken_count}, 0);
    check("arst.addr", redirect_addr, 0);
    #10 reset_n = 1;
    step();
    step();
    outs("arst.after", 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/redirect_controller.md
Name: redirect_controller

Overview:
- Sequences the PC redirect produced by the EX-stage branch/jump unit into the instruction-fetch stage.
- Captures a taken branch, jump or halt when the instruction leaves EX.
- Holds the redirect until fetch accepts it with a valid/ready handshake, and flushes wrong-path instructions from the front end while it waits.
- Owns the halted state, its resume path, and a saturating taken-redirect counter.

Parameters:
- ADDR_W, 32, width of PC and redirect address.
- CNT_W, 32, width of the taken-redirect counter.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a real (non-bubble) instruction.
- ex_stall  in  1  EX holds its instruction this cycle; the instruction does not leave EX.
- ex_jump_valid  in  1  branch unit says redirect (jumpc | jumpr | branch taken | halt).
- ex_jump_addr  in  ADDR_W  branch unit target address.
- ex_halt  in  1  EX instruction is HALT.
- resume  in  1  one-cycle wake request; meaningful only in HALT.
- resume_addr  in  ADDR_W  address to restart fetch from after HALT.
- fetch_ready  in  1  fetch accepts redirect this cycle.
- redirect_valid  out  1  redirect request to fetch (registered).
- redirect_addr  out  ADDR_W  redirect target (registered; stable while redirect_valid=1).
- flush_front  out  1  kill IF/ID contents this cycle.
- flush_ex  out  1  kill EX contents this cycle.
- halted  out  1  core is halted.
- taken_count  out  CNT_W  accepted branch/jump redirects, saturating.

Behaviour:
- Reset (async, reset_n=0): state RUN, redirect_valid=0, redirect_addr=0, flush_front=0, flush_ex=0, halted=0, taken_count=0. Reset mid-WAIT or mid-HALT abandons the pending redirect immediately.
- Capture event: fire = ex_valid & ex_jump_valid & ~ex_stall, sampled only in RUN. While ex_stall=1 nothing is captured, so each instruction redirects at most once.
- States: RUN, WAIT, HALT. All outputs are registered except where stated.
- RUN:
  - fire & ex_halt: next state HALT; halted=1 from the next cycle. No redirect issued; ex_jump_addr is ignored.
  - fire & ~ex_halt: latch redirect_addr=ex_jump_addr and src=BRANCH; next state WAIT.
- WAIT:
  - redirect_valid=1, flush_front=1 and flush_ex=1 in every WAIT cycle; ex_* inputs are ignored because EX holds only wrong-path instructions or bubbles.
  - On redirect_valid & fetch_ready: next state RUN. If src=BRANCH, taken_count += 1, saturating at all-ones.
  - redirect_addr is held constant until accepted.
- Latency: detect in cycle N; redirect_valid, flush_front and flush_ex high in cycle N+1. With fetch_ready=1 at N+1, state is RUN at N+2 and all three deassert at N+2. Minimum 1 flush cycle; otherwise flush lasts as many cycles as fetch_ready stays low.
- HALT:
  - halted=1, flush_front=1, flush_ex=0, redirect_valid=0.
  - resume=1: latch redirect_addr=resume_addr and src=RESUME; next state WAIT. halted deasserts in that same next cycle. A resume-sourced redirect does not increment taken_count.
  - resume outside HALT is ignored.
- Simultaneous events:
  - fire and resume in the same RUN cycle: fire handled, resume dropped.
  - fire & ex_halt & ex_jump_valid: halt wins.
  - fetch_ready while redirect_valid=0 has no effect.
- Width rules: addresses pass through unmodified. Counter saturates and never wraps; 2^CNT_W−1 stays at 2^CNT_W−1.

Decomposition:
- Shared CPU package holds the state encodings (RUN=2'd0, WAIT=2'd1, HALT=2'd2) and the source encodings (BRANCH=1'b0, RESUME=1'b1).
- One sub-module is natural: sat_counter (parameter WIDTH; inputs inc, async clear; output count), reusable for other performance counters.
- The FSM and address register stay in redirect_controller.

Test Plan:
- Reset release, idle inputs → all outputs 0 and state RUN; assert reset_n=0 mid-WAIT → redirect_valid and flush_* drop to 0 asynchronously.
- RUN, ex_valid=1, ex_jump_valid=1, ex_jump_addr=0x0000_1234, fetch_ready=1 → cycle N+1 redirect_valid=1, redirect_addr=0x1234, flush_front=flush_ex=1; cycle N+2 all 0; taken_count=1.
- Same jump with fetch_ready=0 for 3 cycles then 1 → redirect_valid and flush_* high for 4 cycles; redirect_addr stays 0x1234; new ex_jump_valid with addr 0x9999 during WAIT is ignored; taken_count=1.
- ex_stall=1 for 2 cycles with ex_jump_valid=1, then ex_stall=0 → exactly one redirect, issued the cycle after ex_stall falls.
- ex_halt=1 & ex_jump_valid=1, addr 0x40 → halted=1 next cycle, no redirect, flush_front=1; resume=1, resume_addr=0x200 → next cycle redirect_valid=1, addr 0x200, halted=0; taken_count unchanged.
- CNT_W=4: force 16 accepted redirects → taken_count=15 and stays at 15.
